// File: rtl/bin_to_bcd_seq_pkg.sv
// rtl/bin_to_bcd_seq_pkg.sv - shared FSM encodings and BCD adjust constants
//
// Purpose : common definitions for the sequential binary-to-BCD converter.
//           state_t        FSM state encoding (ST_IDLE, ST_SHIFT, ST_DONE)
//           BCD_ADJ_THRESH digit value at or above which +3 is applied
//           BCD_ADJ_ADD    correction added before each left shift
// Ports   : none (package)

package bin_to_bcd_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam logic [3:0] BCD_ADJ_THRESH = 4'd5;
  localparam logic [3:0] BCD_ADJ_ADD    = 4'd3;

endpackage

// File: rtl/bcd_digit_adj.sv
// rtl/bcd_digit_adj.sv - combinational "if >= 5 add 3" BCD digit cell
//
// Purpose : pre-shift correction for one BCD digit of the shift-and-add-3
//           converter. Input range 0..9 maps to at most 4'b1100, so the
//           4-bit sum never wraps.
// Ports   : din   in  4  scratch digit before correction
//           dout  out 4  corrected digit, ready to be shifted left

module bcd_digit_adj
  import bin_to_bcd_seq_pkg::*;
(
  input  logic [3:0] din,
  output logic [3:0] dout
);

  always_comb begin
    if (din >= BCD_ADJ_THRESH) begin
      dout = din + BCD_ADJ_ADD;
    end else begin
      dout = din;
    end
  end

endmodule

// File: rtl/bin_to_bcd_seq.sv
// rtl/bin_to_bcd_seq.sv - sequential binary-to-BCD converter, one bit per clock
//
// Purpose : converts an unsigned W_BIN-bit value to N_DIG BCD digits using
//           shift-and-add-3. Results are held stable between conversions so
//           downstream 7-segment decoders do not flicker.
// Macro   : LEADING_ZERO_BLANK_EN - when defined, o_Blank flags leading-zero
//           digits (digit 0 never blanked, overflow clears the mask); when
//           undefined, o_Blank is tied to 0.
// Ports   : i_Clk       in  1        clock, rising edge
//           i_Reset     in  1        synchronous active-high reset
//           i_Start     in  1        start request, accepted only when idle
//           i_Bin       in  W_BIN    value sampled with an accepted start
//           o_Busy      out 1        conversion in progress
//           o_Done      out 1        one-cycle pulse when results update
//           o_Bcd       out 4*N_DIG  result digits, digit k at [4k+3:4k]
//           o_Overflow  out 1        value did not fit in N_DIG digits
//           o_Blank     out N_DIG    leading-zero blank mask

module bin_to_bcd_seq
  import bin_to_bcd_seq_pkg::*;
#(
  parameter int W_BIN = 16,
  parameter int N_DIG = 5
) (
  input  logic               i_Clk,
  input  logic               i_Reset,
  input  logic               i_Start,
  input  logic [W_BIN-1:0]   i_Bin,
  output logic               o_Busy,
  output logic               o_Done,
  output logic [4*N_DIG-1:0] o_Bcd,
  output logic               o_Overflow,
  output logic [N_DIG-1:0]   o_Blank
);

  localparam int CNT_W = $clog2(W_BIN + 1);
  localparam int BCD_W = 4 * N_DIG;

  state_t             state;
  logic [W_BIN-1:0]   shift_reg;
  logic [BCD_W-1:0]   scratch;
  logic [BCD_W-1:0]   adj;
  logic               ovf_scratch;
  logic [CNT_W-1:0]   cnt;

  // One correction cell per digit; the corrected digits are what gets shifted.
  genvar g;
  generate
    for (g = 0; g < N_DIG; g++) begin : g_dig
      bcd_digit_adj u_adj (
        .din  (scratch[4*g +: 4]),
        .dout (adj[4*g +: 4])
      );
    end
  endgenerate

`ifdef LEADING_ZERO_BLANK_EN
  logic [N_DIG-1:0] blank_next;
  logic             zero_run;

  // Walk from the top digit down; a digit is blank while every digit at or
  // above it is zero. Digit 0 stays visible so a zero result shows "0".
  always_comb begin
    blank_next = '0;
    zero_run   = 1'b1;
    for (int k = N_DIG - 1; k >= 1; k--) begin
      zero_run      = zero_run & (scratch[4*k +: 4] == 4'd0);
      blank_next[k] = zero_run & ~ovf_scratch;
    end
  end
`else
  assign o_Blank = '0;
`endif

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      state       <= ST_IDLE;
      shift_reg   <= '0;
      scratch     <= '0;
      ovf_scratch <= 1'b0;
      cnt         <= '0;
      o_Busy      <= 1'b0;
      o_Done      <= 1'b0;
      o_Bcd       <= '0;
      o_Overflow  <= 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
      o_Blank     <= '0;
`endif
    end else begin
      o_Done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (i_Start) begin
            shift_reg   <= i_Bin;
            scratch     <= '0;
            ovf_scratch <= 1'b0;
            cnt         <= CNT_W'(W_BIN);
            o_Busy      <= 1'b1;
            state       <= ST_SHIFT;
          end
        end

        ST_SHIFT: begin
          // {scratch, shift_reg} shifts left as one long register; whatever
          // leaves the top digit is lost and marks the result as overflowed.
          scratch     <= {adj[BCD_W-2:0], shift_reg[W_BIN-1]};
          shift_reg   <= shift_reg << 1;
          ovf_scratch <= ovf_scratch | adj[BCD_W-1];
          cnt         <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) begin
            state <= ST_DONE;
          end
        end

        ST_DONE: begin
          o_Bcd      <= scratch;
          o_Overflow <= ovf_scratch;
`ifdef LEADING_ZERO_BLANK_EN
          o_Blank    <= blank_next;
`endif
          o_Done     <= 1'b1;
          o_Busy     <= 1'b0;
          state      <= ST_IDLE;
        end

        default: begin
          o_Busy <= 1'b0;
          state  <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
